apb_regfile_slave: RTL and testbench
====================================

// Module: apb_regfile_slave
// PURPOSE
//  Parametrised APB3/APB4 completer fronting a DEPTH x DATA_W register file.
//  Successor to the fixed 8x32 APB slave: adds programmable wait states, real PSLVERR
//  generation (range, alignment, read-only), per-register write protection, optional byte strobes.
//  Sits on the peripheral APB segment behind the bridge; one instance per register bank.
// PARAMETERS
//  DATA_W      32        data width; 8, 16 or 32
//  ADDR_W      8         byte address width; must hold DEPTH*(DATA_W/8) bytes
//  DEPTH       16        number of registers
//  WAIT_CYCLES 0         extra ACCESS cycles before PREADY (0..15)
//  RO_MASK     '0        DEPTH-bit mask; bit i=1 makes register i read-only
// PORTS
//  clk      in   1         clock
//  rst      in   1         reset, asynchronous, active-high
//  psel     in   1         select
//  penable  in   1         access phase
//  pwrite   in   1         1=write 0=read
//  paddr    in   ADDR_W    byte address
//  pwdata   in   DATA_W    write data
//  pstrb    in   DATA_W/8  byte strobes (only with APB_REGFILE_PSTRB_EN)
//  pready   out  1         transfer complete
//  pslverr  out  1         transfer error, valid only while pready=1
//  prdata   out  DATA_W    read data, valid while pready=1 on reads
// BEHAVIOUR
//  - Reset: pready=0, pslverr=0, prdata=0, every register=0, FSM=IDLE, wait counter=0.
//  - FSM: IDLE, ACCESS. IDLE->ACCESS on edge where psel=1,penable=0 (setup cycle); at that edge
//    capture paddr, pwrite, pwdata, pstrb, err flag; on reads load prdata with mem[idx] (0 if err).
//  - idx = paddr[ADDR_W-1:LSB], LSB=$clog2(DATA_W/8).
//  - err = (idx>=DEPTH) | (paddr[LSB-1:0]!=0) | (write & RO_MASK[idx]).
//  - ACCESS: cnt increments each cycle; pready = (state==ACCESS && cnt==WAIT_CYCLES), decoded
//    from registers (no input path). WAIT_CYCLES=0 -> pready high in first access cycle.
//  - pslverr = pready & err_q. Write commits at edge ending the pready cycle iff !err_q.
//  - ACCESS->IDLE at edge ending pready cycle; cnt cleared. Back-to-back: next setup seen in IDLE.
//  - psel dropped in ACCESS (protocol violation): abort to IDLE, no write, pready stays 0.
//  - penable=1 while IDLE: ignored. paddr/pwdata changes during ACCESS: ignored (captured copy).
//  - Errored read returns prdata=0. Errored write leaves the register file unchanged.
//  - rst mid-transfer: immediate return to reset state; partial write never committed.
// CONFIGURATION
//  APB_REGFILE_PSTRB_EN defined: pstrb port exists; write updates only bytes with strobe=1;
//    read with pstrb!=0 sets err (pslverr=1). Write with pstrb=0 completes OK, no change.
//  Not defined: no pstrb port; every write replaces the full word.
// STRUCTURE
//  Package apb_regfile_pkg: state enum (ST_IDLE, ST_ACCESS), err-cause localparams
//  (ERR_RANGE, ERR_ALIGN, ERR_RO), helper fn byte_merge(old,new,strb).
//  Sub-module apb_regfile_mem: DEPTH x DATA_W array, async reset, write port with byte enables,
//  one read port; top holds FSM, counter, error decode.
// TESTING (DATA_W=32, ADDR_W=8, DEPTH=16, RO_MASK=16'h8000 unless noted)
//  1 WAIT_CYCLES=0: write 0xDEADBEEF @0x04, read @0x04 -> pready in 1st access cycle,
//    pslverr=0, prdata=0xDEADBEEF.
//  2 WAIT_CYCLES=3: read @0x00 -> pready high exactly in 4th access cycle, low before it.
//  3 Write 0x1 @0x40 (idx 16) and @0x06 (misaligned) -> pslverr=1 with pready; readback of
//    0x04 unchanged; read @0x40 -> prdata=0, pslverr=1.
//  4 Write 0x12345678 @0x3C (RO reg 15) -> pslverr=1, reg 15 stays 0; read @0x3C ok, prdata=0.
//  5 PSTRB_EN: reg 0=0xAABBCCDD, write 0x11223344 pstrb=4'b0101 -> reads 0xAA22CC44;
//    read with pstrb=4'b0001 -> pslverr=1.
//  6 Assert rst during 2nd ACCESS cycle of write 0xFFFF_FFFF @0x08 (WAIT_CYCLES=3) -> outputs 0,
//    reg 2 reads 0; psel drop mid-ACCESS -> no pready, no write.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the APB register-file completer.
// State encoding, error-cause bit positions and the byte-lane merge function.
package apb_regfile_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Bit positions inside the error-cause vector built at the setup edge
  localparam int ERR_RANGE = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_RO    = 2;
  localparam int ERR_STRB  = 3;
  localparam int ERR_W     = 4;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x DATA_W register array with byte-enabled write port and one
// combinational read port; cleared by the asynchronous reset.
module apb_regfile_mem
  import apb_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_widx,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wstrb,
  input  logic [IDX_W-1:0]      i_ridx,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [31:0]       w_merged;

  // Narrow words are zero-extended into the 32-bit merge helper
  assign w_merged = byte_merge(32'(r_mem[i_widx]), 32'(i_wdata), 4'(i_wstrb));
  assign o_rdata  = r_mem[i_ridx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_widx] <= w_merged[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3/APB4 completer in front of a DEPTH x DATA_W register file with wait
// states and PSLVERR; byte strobes exist only when APB_REGFILE_PSTRB_EN is defined.
module apb_regfile_slave
  import apb_regfile_pkg::*;
#(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 8,
  parameter int              DEPTH       = 16,
  parameter int              WAIT_CYCLES = 0,
  parameter logic [DEPTH-1:0] RO_MASK    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_REGFILE_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic                pready,
  output logic                pslverr,
  output logic [DATA_W-1:0]   prdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_strb;
  logic                r_err;
  logic [DATA_W-1:0]   r_prdata;

  logic [ADDR_W-1:0]   w_fullIdx;
  logic [IDX_W-1:0]    w_idx;
  logic                w_range;
  logic [STRB_W-1:0]   w_strb;
  logic [ERR_W-1:0]    w_errCause;
  logic                w_err;
  logic                w_pready;
  logic                w_we;
  logic [DATA_W-1:0]   w_rdata;

  assign w_fullIdx = paddr >> LSB;
  assign w_idx     = w_fullIdx[IDX_W-1:0];
  assign w_range   = 32'(w_fullIdx) >= DEPTH;

`ifdef APB_REGFILE_PSTRB_EN
  assign w_strb               = pstrb;
  assign w_errCause[ERR_STRB] = !pwrite && (|pstrb);
`else
  assign w_strb               = '1;
  assign w_errCause[ERR_STRB] = 1'b0;
`endif

  // RO lookup is gated by the range check so an out-of-range index never selects a mask bit
  assign w_errCause[ERR_RANGE] = w_range;
  assign w_errCause[ERR_ALIGN] = |(paddr & ALIGN_MASK);
  assign w_errCause[ERR_RO]    = pwrite && !w_range && RO_MASK[w_idx];
  assign w_err                 = |w_errCause;

  assign w_pready = (r_state == ST_ACCESS) && (r_cnt == 4'(WAIT_CYCLES));
  assign w_we     = w_pready && psel && r_write && !r_err;

  assign pready  = w_pready;
  assign pslverr = w_pready && r_err;
  assign prdata  = r_prdata;

  apb_regfile_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (r_wdata),
    .i_wstrb (r_strb),
    .i_ridx  (w_idx),
    .o_rdata (w_rdata)
  );

  // Setup edge captures the request; a dropped psel mid-access aborts without writing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_err    <= 1'b0;
      r_prdata <= '0;
    end else if (r_state == ST_IDLE) begin
      if (psel && !penable) begin
        r_state <= ST_ACCESS;
        r_cnt   <= '0;
        r_idx   <= w_idx;
        r_write <= pwrite;
        r_wdata <= pwdata;
        r_strb  <= w_strb;
        r_err   <= w_err;
        if (!pwrite) r_prdata <= w_err ? '0 : w_rdata;
      end
    end else begin
      if (!psel || w_pready) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: two instances (0 and 3 wait states)
// share the bus but have separate selects; define APB_REGFILE_PSTRB_EN to run strobe cases.
module tb_apb_regfile_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel0, psel3, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready0, pslverr0, pready3, pslverr3;
  logic [31:0] prdata0, prdata3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    bit          isRead;
    bit          expErr;
    logic [31:0] expData;
    int          expWaits;
  } exp_t;
  exp_t sbQ[$];

  always #5 clk = ~clk;

  apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(0), .RO_MASK(16'h8000)) dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_REGFILE_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(pready0), .pslverr(pslverr0), .prdata(prdata0));

  apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(3), .RO_MASK(16'h8000)) dut3 (
    .clk(clk), .rst(rst), .psel(psel3), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_REGFILE_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(pready3), .pslverr(pslverr3), .prdata(prdata3));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One full APB transfer; the expectation is queued at setup and retired when pready rises
  task automatic applyStimulus(input string tag, input int dutSel, input bit wr, input logic [7:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input bit expErr, input logic [31:0] expData);
    exp_t e;
    int   waits;
    logic rdy;
    sbQ.push_back('{tag, !wr, expErr, expData, (dutSel == 0) ? 0 : 3});
    @(posedge clk); #1;
    psel0 = (dutSel == 0); psel3 = (dutSel != 0);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr = addr ^ 8'h04; pwdata = ~data;
    waits = 0;
    rdy = (dutSel == 0) ? pready0 : pready3;
    while (!rdy && waits < 20) begin
      @(posedge clk); #1;
      waits++;
      rdy = (dutSel == 0) ? pready0 : pready3;
    end
    if (!rdy) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sbQ.pop_front());
    end else if (sbQ.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      checkOutput({e.tag, "_waits"}, 32'(waits), 32'(e.expWaits));
      checkOutput({e.tag, "_pslverr"}, 32'((dutSel == 0) ? pslverr0 : pslverr3), 32'(e.expErr));
      if (e.isRead) checkOutput({e.tag, "_prdata"}, (dutSel == 0) ? prdata0 : prdata3, e.expData);
    end
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pready0", 32'(pready0), 32'd0);
    checkOutput("rst_pslverr0", 32'(pslverr0), 32'd0);
    checkOutput("rst_prdata0", prdata0, 32'd0);
    checkOutput("rst_pready3", 32'(pready3), 32'd0);
    checkOutput("rst_prdata3", prdata3, 32'd0);
    rst = 1'b0;

    // penable without a setup phase must not start a transfer
    psel0 = 1'b1; penable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("idle_penable_pready", 32'(pready0), 32'd0);
    end
    psel0 = 1'b0; penable = 1'b0;

    applyStimulus("t1_wr04", 0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    applyStimulus("t1_rd04", 0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);

    applyStimulus("t2_rd00", 3, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'h0);
    applyStimulus("t2_wr00", 3, 1'b1, 8'h00, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
    applyStimulus("t2_rd00b", 3, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);

    applyStimulus("t3_wr40", 0, 1'b1, 8'h40, 32'h1, 4'hF, 1'b1, 32'h0);
    applyStimulus("t3_wr06", 0, 1'b1, 8'h06, 32'h1, 4'hF, 1'b1, 32'h0);
    applyStimulus("t3_rd04", 0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
    applyStimulus("t3_rd40", 0, 1'b0, 8'h40, 32'h0, 4'h0, 1'b1, 32'h0);
    applyStimulus("t3_rd05", 0, 1'b0, 8'h05, 32'h0, 4'h0, 1'b1, 32'h0);

    applyStimulus("t4_wr3c", 0, 1'b1, 8'h3C, 32'h12345678, 4'hF, 1'b1, 32'h0);
    applyStimulus("t4_rd3c", 0, 1'b0, 8'h3C, 32'h0, 4'h0, 1'b0, 32'h0);
    applyStimulus("t4_wr38", 0, 1'b1, 8'h38, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
    applyStimulus("t4_rd38", 0, 1'b0, 8'h38, 32'h0, 4'h0, 1'b0, 32'h0BADF00D);

`ifdef APB_REGFILE_PSTRB_EN
    applyStimulus("t5_wr00", 0, 1'b1, 8'h00, 32'hAABBCCDD, 4'hF, 1'b0, 32'h0);
    applyStimulus("t5_wrstrb", 0, 1'b1, 8'h00, 32'h11223344, 4'b0101, 1'b0, 32'h0);
    applyStimulus("t5_rd00", 0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'hAA22CC44);
    applyStimulus("t5_rdstrb", 0, 1'b0, 8'h00, 32'h0, 4'b0001, 1'b1, 32'h0);
    applyStimulus("t5_wrnostrb", 0, 1'b1, 8'h00, 32'h99999999, 4'h0, 1'b0, 32'h0);
    applyStimulus("t5_rd00b", 0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'hAA22CC44);
`endif

    // Reset lands in the second access cycle of a write that would otherwise commit
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6_prdata_before_rst", prdata3, 32'hCAFEF00D);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_pready", 32'(pready3), 32'd0);
    checkOutput("t6_rst_pslverr", 32'(pslverr3), 32'd0);
    checkOutput("t6_rst_prdata", prdata3, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; psel3 = 1'b0; penable = 1'b0;
    applyStimulus("t6_rd08", 3, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, 32'h0);
    applyStimulus("t6_rd04_dut0", 0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0, 32'h0);

    // psel withdrawn during the wait states: no completion and no write
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h0000_0055;
    @(posedge clk); #1;
    penable = 1'b1;
    checkOutput("t6_abort_pready_c1", 32'(pready3), 32'd0);
    @(posedge clk); #1;
    checkOutput("t6_abort_pready_c2", 32'(pready3), 32'd0);
    psel3 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("t6_abort_pready_after", 32'(pready3), 32'd0);
    end
    applyStimulus("t6_rd0c", 3, 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0, 32'h0);

    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
